wb_trace_tx: RTL and testbench
==============================

WB_TRACE_TX -- requirements
Module: wb_trace_tx

Interface
REQ-001 Parameter: DEPTH, 8, number of writeback-event FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 RegWrite  input  1  writeback-stage register write strobe from the pipeline.
REQ-005 A3  input  4  destination register index of the writeback.
REQ-006 WD3  input  32  value written to the register file.
REQ-007 ALUFlags  input  4  NZCV flags accompanying the event (used only with TRACE_FLAGS_EN).
REQ-008 BranchTaken  input  1  branch-taken indication (used only with TRACE_FLAGS_EN).
REQ-009 tx_data  output  8  trace byte presented to the consumer.
REQ-010 tx_valid  output  1  tx_data holds a valid byte.
REQ-011 tx_ready  input  1  consumer accepts the byte; transfer occurs on a rising edge when tx_valid and tx_ready are both 1.
REQ-012 overflow  output  1  sticky flag: at least one event was dropped.
REQ-013 fifo_count  output  5  number of queued events, including the frame currently being sent.

Function
REQ-014 On each rising edge with RegWrite=1, the block SHALL push {A3, WD3}, plus {ALUFlags, BranchTaken} when configured, into the FIFO; A3=0 is captured like any other index.
REQ-015 When the FIFO is full and no pop occurs on that edge, the push SHALL be dropped, overflow SHALL be set, and the FIFO contents SHALL remain unchanged.
REQ-016 A simultaneous push and pop SHALL both take effect, including when the FIFO is full; fifo_count is unchanged and overflow is not set.
REQ-017 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-018 Serializer FSM states: IDLE, HDR, D3, D2, D1, D0 (plus FLG when configured).
REQ-019 IDLE->HDR on the edge where fifo_count>0; an event pushed into an empty FIFO at edge N SHALL produce tx_valid=1 after edge N+1.
REQ-020 tx_valid SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-021 Byte order: HDR = {4'hA, A3}, then D3..D0 = WD3[31:24], [23:16], [15:8], [7:0].
REQ-022 The FSM advances one state only on a transfer; tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-023 The FIFO head SHALL be read in place and popped only on the transfer of the frame's last byte.
REQ-024 On the last-byte transfer the FSM SHALL go to HDR if fifo_count>1 before the pop (no idle gap between frames), otherwise to IDLE.
REQ-025 tx_ready is ignored in IDLE; pushes during an in-flight frame do not disturb the frame.

Reset
REQ-026 While reset=1: FIFO emptied, pointers=0, FSM=IDLE, tx_valid=0, tx_data=0, overflow=0, fifo_count=0; asynchronous assertion.
REQ-027 Reset mid-frame SHALL abandon the frame; no partial frame resumes after reset deasserts.
REQ-028 RegWrite SHALL NOT be captured on any edge where reset=1.

Configuration
REQ-029 Macro TRACE_FLAGS_EN defined: FIFO entries widen by 5 bits, and after D0 the FLG byte {3'b000, BranchTaken, ALUFlags} is sent; frame = 6 bytes, popped on FLG.
REQ-030 Macro TRACE_FLAGS_EN undefined: frame = 5 bytes, popped on D0; ALUFlags/BranchTaken unused and no FLG state exists.

Verification
REQ-031 Single event A3=3, WD3=0x12345678, tx_ready=1 -> bytes A3,12,34,56,78 on consecutive cycles; tx_valid=1 starting 2nd cycle after push, then 0.
REQ-032 tx_ready held 0 for 4 cycles during D2 -> tx_data stays 0x34, tx_valid stays 1, fifo_count stays 1.
REQ-033 tx_ready=0, 9 consecutive pushes with DEPTH=8 -> fifo_count=8, overflow=1; 8 frames follow back-to-back once tx_ready=1.
REQ-034 FIFO full, push coincident with last-byte transfer -> fifo_count stays 8, overflow stays 0.
REQ-035 Reset asserted during D1 -> tx_valid=0 immediately; after release, no bytes sent until a new RegWrite.
REQ-036 TRACE_FLAGS_EN defined, ALUFlags=4'b1001, BranchTaken=1 -> 6th byte=0x19.

Source files
------------

// File: rtl/wb_trace_tx.sv
// Writeback-event trace transmitter: queues {A3, WD3} events in a FIFO and sends each one as a byte-serial frame.
// Optional macro TRACE_FLAGS_EN adds a FLG byte {3'b000, BranchTaken, ALUFlags} to every frame.
module wb_trace_tx #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [3:0]  A3,
    input  logic [31:0] WD3,
    input  logic [3:0]  ALUFlags,
    input  logic        BranchTaken,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [4:0]  fifo_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef TRACE_FLAGS_EN
    localparam int unsigned EW = 41;
`else
    localparam int unsigned EW = 36;
`endif

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        D3,
        D2,
        D1,
`ifdef TRACE_FLAGS_EN
        D0,
        FLG
`else
        D0
`endif
    } state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic          r_overflow;
    state_t        r_state;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;

    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_next;
    logic [AW-1:0] w_rptr_nx;
    logic          w_xfer;
    logic          w_last;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    state_t        w_succ;

`ifdef TRACE_FLAGS_EN
    assign w_entry = {BranchTaken, ALUFlags, A3, WD3};
    assign w_last  = (r_state == FLG);
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{ALUFlags, BranchTaken};
    assign w_entry = {A3, WD3};
    assign w_last  = (r_state == D0);
`endif

    assign w_rptr_nx = r_rptr + 1'b1;
    assign w_head    = r_mem[r_rptr];
    assign w_next    = r_mem[w_rptr_nx];
    assign w_xfer    = r_tx_valid && tx_ready;
    assign w_pop     = w_xfer && w_last;
    assign w_full    = (r_count == 5'(DEPTH));
    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign w_push    = RegWrite && (!w_full || w_pop);

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

    function automatic logic [7:0] byte_of(input state_t s, input logic [EW-1:0] e);
        case (s)
            HDR:     byte_of = {4'hA, e[35:32]};
            D3:      byte_of = e[31:24];
            D2:      byte_of = e[23:16];
            D1:      byte_of = e[15:8];
            D0:      byte_of = e[7:0];
`ifdef TRACE_FLAGS_EN
            FLG:     byte_of = {3'b000, e[40:36]};
`endif
            default: byte_of = '0;
        endcase
    endfunction

    always_comb begin
        w_succ = IDLE;
        case (r_state)
            HDR:     w_succ = D3;
            D3:      w_succ = D2;
            D2:      w_succ = D1;
            D1:      w_succ = D0;
`ifdef TRACE_FLAGS_EN
            D0:      w_succ = FLG;
`endif
            default: w_succ = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nx;
            end
            if (RegWrite && !w_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // tx_data is loaded with the byte of the state being entered, so it is registered and stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= HDR;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= byte_of(HDR, w_head);
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            if (r_count > 5'd1) begin
                                r_state   <= HDR;
                                r_tx_data <= byte_of(HDR, w_next);
                            end else begin
                                r_state    <= IDLE;
                                r_tx_valid <= 1'b0;
                                r_tx_data  <= '0;
                            end
                        end else begin
                            r_state   <= w_succ;
                            r_tx_data <= byte_of(w_succ, w_head);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_tx.sv
// Randomized and directed bench for wb_trace_tx against a queue-based frame model.
module tb_wb_trace_tx;
    localparam int unsigned DEPTH = 8;
`ifdef TRACE_FLAGS_EN
    localparam int unsigned FRAME = 6;
`else
    localparam int unsigned FRAME = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [3:0]  ALUFlags;
    logic        BranchTaken;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [4:0]  fifo_count;

    wb_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWrite    (RegWrite),
        .A3          (A3),
        .WD3         (WD3),
        .ALUFlags    (ALUFlags),
        .BranchTaken (BranchTaken),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a3;
        logic [31:0] wd;
        logic [3:0]  fl;
        logic        bt;
    } ev_t;

    ev_t         q[$];
    int unsigned bidx;
    bit          sending;
    bit          m_ovf;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] frame_byte(input ev_t e, input int unsigned i);
        case (i)
            0:       return {4'hA, e.a3};
            1:       return e.wd[31:24];
            2:       return e.wd[23:16];
            3:       return e.wd[15:8];
            4:       return e.wd[7:0];
            5:       return {3'b000, e.bt, e.fl};
            default: return 8'h00;
        endcase
    endfunction

    // Advances the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int unsigned sz;
        bit          popped;
        ev_t         ev;
        sz = q.size();
        popped = 0;
        if (sending && tx_ready) begin
            bidx++;
            if (bidx == FRAME) begin
                popped = 1;
                bidx = 0;
                void'(q.pop_front());
                sending = (sz > 1);
            end
        end else if (!sending && sz > 0) begin
            sending = 1;
            bidx = 0;
        end
        if (RegWrite) begin
            ev.a3 = A3;
            ev.wd = WD3;
            ev.fl = ALUFlags;
            ev.bt = BranchTaken;
            if (sz < DEPTH || popped) q.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    task automatic compare();
        check("valid", tx_valid, sending);
        check("count", fifo_count, q.size());
        check("ovf", overflow, m_ovf);
        if (sending) check("data", tx_data, frame_byte(q[0], bidx));
    endtask

    task automatic cycle(input logic rw, input logic [3:0] a, input logic [31:0] d, input logic rdy,
                         input logic [3:0] fl = 4'h0, input logic bt = 1'b0);
        RegWrite = rw;
        A3 = a;
        WD3 = d;
        tx_ready = rdy;
        ALUFlags = fl;
        BranchTaken = bt;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        RegWrite = 1'b1;
        A3 = 4'h5;
        WD3 = 32'hDEADBEEF;
        tx_ready = 1'b1;
        q.delete();
        sending = 0;
        bidx = 0;
        m_ovf = 0;
        repeat (2) @(negedge clk);
        compare();
        check("rst_data", tx_data, 8'h00);
        reset = 1'b0;
        RegWrite = 1'b0;
    endtask

    task automatic run_to(input int unsigned idx);
        int unsigned n;
        n = 0;
        while (!(sending && bidx == idx) && n < 20) begin
            cycle(1'b0, 4'h0, 32'h0, 1'b1);
            n++;
        end
        check("run_to_timeout", (sending && bidx == idx), 1);
    endtask

    initial begin
        logic [7:0]  seen[$];
        logic [7:0]  exp31[5];
        int unsigned nv;
        int unsigned rate;

        reset = 1'b1;
        RegWrite = 1'b0;
        A3 = '0;
        WD3 = '0;
        ALUFlags = '0;
        BranchTaken = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single event, consumer always ready
        exp31 = '{8'hA3, 8'h12, 8'h34, 8'h56, 8'h78};
        cycle(1'b1, 4'h3, 32'h12345678, 1'b1);
        check("lat_edgeN", tx_valid, 0);
        cycle(1'b0, 4'h0, 32'h0, 1'b1);
        check("lat_edgeN1", tx_valid, 1);
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) seen.push_back(tx_data);
            cycle(1'b0, 4'h0, 32'h0, 1'b1);
        end
        check("frame_len", seen.size(), FRAME);
        for (int i = 0; i < 5; i++) check("frame_byte", seen[i], exp31[i]);
        check("idle_after", tx_valid, 0);

        // Back-pressure during D2
        cycle(1'b1, 4'h3, 32'h12345678, 1'b1);
        run_to(2);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'h0, 32'h0, 1'b0);
            check("stall_data", tx_data, 8'h34);
            check("stall_valid", tx_valid, 1);
            check("stall_count", fifo_count, 1);
        end
        repeat (8) cycle(1'b0, 4'h0, 32'h0, 1'b1);

        // Overflow: nine pushes with the consumer stalled, then back-to-back drain
        for (int i = 0; i < 9; i++) cycle(1'b1, 4'($urandom), $urandom, 1'b0);
        check("full_count", fifo_count, DEPTH);
        check("full_ovf", overflow, 1);
        nv = 0;
        for (int i = 0; i < DEPTH * FRAME + 1; i++) begin
            if (tx_valid) nv++;
            cycle(1'b0, 4'h0, 32'h0, 1'b1);
        end
        check("b2b_valid_cycles", nv, DEPTH * FRAME);

        // Push coincident with last-byte transfer on a full FIFO
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'($urandom), $urandom, 1'b0);
        check("fill_count", fifo_count, DEPTH);
        run_to(FRAME - 1);
        cycle(1'b1, 4'hC, 32'hCAFEF00D, 1'b1);
        check("pushpop_count", fifo_count, DEPTH);
        check("pushpop_ovf", overflow, 0);
        repeat (DEPTH * FRAME + 4) cycle(1'b0, 4'h0, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a frame
        cycle(1'b1, 4'h9, 32'h0BADF00D, 1'b1);
        run_to(3);
        reset = 1'b1;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_count", fifo_count, 0);
        apply_reset();
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'h0, 32'h0, 1'b1);
            if (tx_valid) nv++;
        end
        check("no_resume", nv, 0);

`ifdef TRACE_FLAGS_EN
        cycle(1'b1, 4'h1, 32'h00000000, 1'b1, 4'b1001, 1'b1);
        run_to(5);
        check("flg_byte", tx_data, 8'h19);
        repeat (4) cycle(1'b0, 4'h0, 32'h0, 1'b1);
`endif

        // Randomized traffic with varying push and ready rates
        apply_reset();
        for (int p = 0; p < 15; p++) begin
            rate = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                cycle(1'($urandom_range(0, 99) < 45), 4'($urandom), $urandom,
                      1'($urandom_range(0, 99) < rate), 4'($urandom), 1'($urandom));
            end
            if (p == 7) apply_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
